// File: rtl/microwave_timer.sv
// Microwave cook timer: one-hot CLOSED/COOK/PAUSE/BELL/OPEN controller with a
// prescaled cook-time countdown, PWM power control and a fixed-length bell.
module microwave_timer #(
  parameter int TIME_W   = 8,
  parameter int TICK_DIV = 4,
  parameter int PWR_W    = 2,
  parameter int BELL_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              door,
  input  logic              start,
  input  logic              cancel,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power,
  output logic              heat,
  output logic              light,
  output logic              bell,
  output logic              done,
  output logic [TIME_W-1:0] remaining,
  output logic [4:0]        dbg_state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BELL_LEN > 1) ? $clog2(BELL_LEN) : 1;

  localparam logic [4:0] ST_CLOSED = 5'b00001;
  localparam logic [4:0] ST_COOK   = 5'b00010;
  localparam logic [4:0] ST_PAUSE  = 5'b00100;
  localparam logic [4:0] ST_BELL   = 5'b01000;
  localparam logic [4:0] ST_OPEN   = 5'b10000;

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0]     BELL_LAST = BW'(BELL_LEN - 1);
  localparam logic [TIME_W-1:0] TIME_ONE  = TIME_W'(1);

  logic [4:0]        state_q,  state_d;
  logic [TIME_W-1:0] remain_q, remain_d;
  logic [PWR_W-1:0]  pwr_q,    pwr_d;
  logic [TW-1:0]     tick_q,   tick_d;
  logic [PWR_W-1:0]  pwm_q,    pwm_d;
  logic [BW-1:0]     bell_q,   bell_d;

  // State register together with the datapath registers it steers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CLOSED;
      remain_q <= '0;
      pwr_q    <= '0;
      tick_q   <= '0;
      pwm_q    <= '0;
      bell_q   <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      pwr_q    <= pwr_d;
      tick_q   <= tick_d;
      pwm_q    <= pwm_d;
      bell_q   <= bell_d;
    end
  end

  // Next-state and datapath update; every register holds unless a branch moves it.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    pwr_d    = pwr_q;
    tick_d   = tick_q;
    pwm_d    = pwm_q;
    bell_d   = bell_q;
    case (state_q)
      ST_CLOSED: begin
        if (load) begin
          remain_d = time_in;
          pwr_d    = power;
        end
        if (door) begin
          state_d = ST_OPEN;
        end else if (start && !load && (remain_q != '0)) begin
          state_d = ST_COOK;
          tick_d  = '0;
          pwm_d   = '0;
        end
      end
      ST_COOK: begin
        if (door) begin
          state_d = ST_PAUSE;
        end else if (cancel) begin
          state_d  = ST_CLOSED;
          remain_d = '0;
        end else begin
          pwm_d = pwm_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            remain_d = remain_q - TIME_ONE;
            if (remain_q == TIME_ONE) begin
              state_d = ST_BELL;
              bell_d  = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        // Cancel while paused leaves the door open, hence OPEN rather than CLOSED.
        if (cancel) begin
          state_d  = ST_OPEN;
          remain_d = '0;
        end else if (!door) begin
          state_d = ST_COOK;
        end
      end
      ST_BELL: begin
        if (door) begin
          state_d = ST_OPEN;
        end else if (bell_q == BELL_LAST) begin
          state_d = ST_CLOSED;
        end else begin
          bell_d = bell_q + 1'b1;
        end
      end
      ST_OPEN: begin
        if (!door) begin
          state_d = ST_CLOSED;
        end
      end
      default: begin
        state_d = ST_CLOSED;
      end
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    heat      = (state_q == ST_COOK) && (pwm_q <= pwr_q);
    light     = (state_q == ST_COOK) || (state_q == ST_PAUSE) || (state_q == ST_OPEN);
    bell      = (state_q == ST_BELL);
    done      = (state_q == ST_BELL) && (bell_q == '0);
    remaining = remain_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_microwave_timer.sv
// Directed scenario bench for microwave_timer: each driven cycle pushes the
// expected post-edge output vector; a monitor pops and compares it.
module tb_microwave_timer;

  localparam int W = 17;
  localparam logic [4:0] ST_CLOSED = 5'b00001;
  localparam logic [4:0] ST_COOK   = 5'b00010;
  localparam logic [4:0] ST_PAUSE  = 5'b00100;
  localparam logic [4:0] ST_BELL   = 5'b01000;
  localparam logic [4:0] ST_OPEN   = 5'b10000;

  logic       clk;
  logic       rst, door, start, cancel, load;
  logic [7:0] time_in;
  logic [1:0] power;
  logic       heat, light, bell, done;
  logic [7:0] remaining;
  logic [4:0] dbg_state;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  microwave_timer dut (
    .clk       (clk),
    .rst       (rst),
    .door      (door),
    .start     (start),
    .cancel    (cancel),
    .load      (load),
    .time_in   (time_in),
    .power     (power),
    .heat      (heat),
    .light     (light),
    .bell      (bell),
    .done      (done),
    .remaining (remaining),
    .dbg_state (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%b h/l/b/d=%b rem=%0d, expected st=%b h/l/b/d=%b rem=%0d",
               tag, got[16:12], got[11:8], got[7:0], exp[16:12], exp[11:8], exp[7:0]);
    end
  endtask

  // Expected output vector: light and bell follow from the state by definition.
  function automatic logic [W-1:0] ev(input logic [4:0] st, input logic h, input logic d,
                                      input logic [7:0] rem);
    logic l, b;
    l = (st == ST_COOK) || (st == ST_PAUSE) || (st == ST_OPEN);
    b = (st == ST_BELL);
    return {st, h, l, b, d, rem};
  endfunction

  // driver: inputs applied at the falling edge, result expected after the next rising edge
  task automatic cyc(input logic r, input logic d, input logic s, input logic c, input logic l,
                     input logic [7:0] t, input logic [1:0] p, input string tag,
                     input logic [W-1:0] e);
    @(negedge clk);
    rst = r; door = d; start = s; cancel = c; load = l; time_in = t; power = p;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag, input logic [W-1:0] e);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), tag, e);
  endtask

  // Cook cycles k0..k1 (1-based counting cycles, PWM cleared at start). load is
  // toggled randomly because it must be ignored outside CLOSED.
  task automatic cook_span(input int k0, input int k1, input int ticks, input int pwr);
    for (int k = k0; k <= k1; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          2'($urandom_range(0, 3)), "cook",
          ev(ST_COOK, ((k - 1) % 4) <= pwr, 1'b0, 8'(ticks - (k - 1) / 4)));
    end
  endtask

  task automatic end_cook();
    idle("bell_first", ev(ST_BELL, 1'b0, 1'b1, 8'd0));
    idle("bell_2", ev(ST_BELL, 1'b0, 1'b0, 8'd0));
    idle("bell_3", ev(ST_BELL, 1'b0, 1'b0, 8'd0));
    idle("after_bell", ev(ST_CLOSED, 1'b0, 1'b0, 8'd0));
  endtask

  // scoreboard monitor
  always @(posedge clk) begin : monitor
    logic [W-1:0] e;
    string        t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {dbg_state, heat, light, bell, done, remaining}, e);
    end
  end

  initial begin
    rst = 1'b1; door = 1'b0; start = 1'b0; cancel = 1'b0; load = 1'b0;
    time_in = 8'd0; power = 2'd0;

    cyc(1, 0, 0, 0, 0, 8'd0, 2'd0, "reset", ev(ST_CLOSED, 0, 0, 8'd0));
    cyc(1, 1, 1, 0, 1, 8'd9, 2'd3, "rst_override", ev(ST_CLOSED, 0, 0, 8'd0));

    // full cook, continuous heat
    cyc(0, 0, 0, 0, 1, 8'd3, 2'd3, "load3", ev(ST_CLOSED, 0, 0, 8'd3));
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start3", ev(ST_COOK, 1, 0, 8'd3));
    cook_span(2, 12, 3, 3);
    end_cook();

    // power 1 PWM pattern
    cyc(0, 0, 0, 0, 1, 8'd2, 2'd1, "load2", ev(ST_CLOSED, 0, 0, 8'd2));
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start2", ev(ST_COOK, 1, 0, 8'd2));
    cook_span(2, 8, 2, 1);
    end_cook();

    // pause after 5 counting cycles, then resume
    cyc(0, 0, 0, 0, 1, 8'd3, 2'd2, "load_p", ev(ST_CLOSED, 0, 0, 8'd3));
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start_p", ev(ST_COOK, 1, 0, 8'd3));
    cook_span(2, 6, 3, 2);
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 0, 0, 1, 8'd7, 2'd0, "pause", ev(ST_PAUSE, 0, 0, 8'd2));
    cyc(0, 0, 0, 0, 0, 8'd0, 2'd0, "resume", ev(ST_COOK, 1, 0, 8'd2));
    cook_span(7, 12, 3, 2);
    end_cook();

    // start with nothing loaded, load+start together
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start_zero", ev(ST_CLOSED, 0, 0, 8'd0));
    cyc(0, 0, 1, 0, 1, 8'd5, 2'd2, "load_start", ev(ST_CLOSED, 0, 0, 8'd5));
    idle("no_start", ev(ST_CLOSED, 0, 0, 8'd5));
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start5", ev(ST_COOK, 1, 0, 8'd5));
    cyc(0, 0, 0, 1, 0, 8'd0, 2'd0, "cancel_cook", ev(ST_CLOSED, 0, 0, 8'd0));

    // door opens in second bell cycle
    cyc(0, 0, 0, 0, 1, 8'd1, 2'd0, "load1", ev(ST_CLOSED, 0, 0, 8'd1));
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start1", ev(ST_COOK, 1, 0, 8'd1));
    cook_span(2, 4, 1, 0);
    idle("bell_first", ev(ST_BELL, 0, 1, 8'd0));
    idle("bell_2", ev(ST_BELL, 0, 0, 8'd0));
    cyc(0, 1, 0, 0, 0, 8'd0, 2'd0, "bell_door", ev(ST_OPEN, 0, 0, 8'd0));
    cyc(0, 1, 0, 0, 1, 8'd9, 2'd1, "open_load", ev(ST_OPEN, 0, 0, 8'd0));
    cyc(0, 0, 0, 0, 0, 8'd0, 2'd0, "close", ev(ST_CLOSED, 0, 0, 8'd0));

    // cancel while paused
    cyc(0, 0, 0, 0, 1, 8'd2, 2'd3, "load_pc", ev(ST_CLOSED, 0, 0, 8'd2));
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start_pc", ev(ST_COOK, 1, 0, 8'd2));
    cyc(0, 1, 0, 0, 0, 8'd0, 2'd0, "pause_pc", ev(ST_PAUSE, 0, 0, 8'd2));
    cyc(0, 1, 0, 1, 0, 8'd0, 2'd0, "pause_cancel", ev(ST_OPEN, 0, 0, 8'd0));
    cyc(0, 0, 0, 0, 0, 8'd0, 2'd0, "close_pc", ev(ST_CLOSED, 0, 0, 8'd0));

    // load with door open, then cook at that power
    cyc(0, 1, 0, 0, 1, 8'd6, 2'd1, "load_open", ev(ST_OPEN, 0, 0, 8'd6));
    cyc(0, 0, 0, 0, 0, 8'd0, 2'd0, "close_lo", ev(ST_CLOSED, 0, 0, 8'd6));
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start6", ev(ST_COOK, 1, 0, 8'd6));
    cook_span(2, 4, 6, 1);
    cyc(0, 0, 0, 1, 0, 8'd0, 2'd0, "cancel6", ev(ST_CLOSED, 0, 0, 8'd0));

    // reset mid-cook
    cyc(0, 0, 0, 0, 1, 8'd4, 2'd3, "load4", ev(ST_CLOSED, 0, 0, 8'd4));
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start4", ev(ST_COOK, 1, 0, 8'd4));
    cook_span(2, 3, 4, 3);
    cyc(1, 0, 0, 0, 0, 8'd0, 2'd0, "rst_cook", ev(ST_CLOSED, 0, 0, 8'd0));
    cyc(0, 0, 1, 0, 0, 8'd0, 2'd0, "start_after_rst", ev(ST_CLOSED, 0, 0, 8'd0));

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microwave_timer.md
MICROWAVE_TIMER -- requirements
Module: microwave_timer

Interface
REQ-001 Parameter TIME_W, default 8: width of the cook-time counter, in ticks.
REQ-002 Parameter TICK_DIV, default 4: clk cycles per cook-time tick; SHALL be at least 2.
REQ-003 Parameter PWR_W, default 2: width of the power-level field; the heat PWM period is 2**PWR_W cycles.
REQ-004 Parameter BELL_LEN, default 3: bell duration in clk cycles; SHALL be at least 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 door  input  1  1 = door open.
REQ-008 start  input  1  request to begin cooking.
REQ-009 cancel  input  1  abort the current cook.
REQ-010 load  input  1  capture time_in and power.
REQ-011 time_in  input  TIME_W  cook time, in ticks.
REQ-012 power  input  PWR_W  power level: 0 = lowest, all-ones = continuous heat.
REQ-013 heat  output  1  magnetron enable.
REQ-014 light  output  1  interior lamp.
REQ-015 bell  output  1  end-of-cook bell.
REQ-016 done  output  1  single-cycle pulse marking cook completion.
REQ-017 remaining  output  TIME_W  ticks left in the current cook.

Function
REQ-018 The controller SHALL have exactly five states, CLOSED, COOK, PAUSE, BELL and OPEN, held in a one-hot register.
REQ-019 heat, light, bell and done SHALL be combinational decodes of registered state only, with no input-to-output paths.
REQ-020 CLOSED transitions, first match wins:
- door = 1 -> OPEN.
- else start = 1, load = 0 and remaining != 0 -> COOK.
- else stay in CLOSED.
REQ-021 In CLOSED, load = 1 SHALL register time_in into remaining and power into pwr_reg, regardless of door.
- load = 1 together with start = 1 loads the values and ignores start.
- load is ignored in every state other than CLOSED.
REQ-022 On entry to COOK from CLOSED, the tick counter and the PWM counter SHALL both be cleared to 0.
REQ-023 COOK transitions, first match wins:
- door = 1 -> PAUSE; counters freeze.
- cancel = 1 -> CLOSED; remaining cleared to 0.
- else counting per REQ-024.
REQ-024 COOK counting, each cycle with no door or cancel:
- If tick_cnt == TICK_DIV-1: tick_cnt <- 0 and remaining decrements by 1; if remaining was 1, next state is BELL.
- Otherwise tick_cnt increments by 1.
- Result: a cook of N ticks lasts exactly N*TICK_DIV COOK cycles.
REQ-025 The PWM counter SHALL increment modulo 2**PWR_W on every cycle spent in COOK, and SHALL hold its value in all other states.
REQ-026 heat SHALL be 1 only when in COOK and pwm_cnt <= pwr_reg.
REQ-027 PAUSE transitions, first match wins:
- cancel = 1 -> OPEN; remaining cleared to 0.
- door = 0 -> COOK; tick and PWM counters resume from their frozen values, not cleared.
- else stay in PAUSE.
REQ-028 BELL behaviour:
- bell_cnt is cleared on entry.
- door = 1 -> OPEN, taking priority over bell_cnt.
- Else if bell_cnt == BELL_LEN-1 -> CLOSED.
- Else bell_cnt increments by 1.
REQ-029 OPEN: door = 0 -> CLOSED; otherwise stay in OPEN.
REQ-030 Output decodes:
- bell = BELL.
- light = COOK | PAUSE | OPEN.
- done = 1 only in the first BELL cycle.
REQ-031 remaining SHALL be 0 whenever the controller is in BELL.

Reset
REQ-032 With rst = 1 at a clk edge, from any state including mid-COOK:
- State, remaining, pwr_reg, tick_cnt, pwm_cnt and bell_cnt all cleared; state goes to CLOSED.
- All outputs 0 from the following cycle.
- rst overrides every other input.

Verification
REQ-033 The bench SHALL cover the following directed scenarios (default parameters, door = 0 unless stated):
- load time_in=3 power=3, then start -> COOK next cycle; heat = 1 for 12 cycles; remaining steps 3,2,1,0 every 4 cycles; bell = 1 for 3 cycles with done in the first; then CLOSED.
- power=1, time_in=2 -> heat pattern 1,1,0,0 repeating over 8 COOK cycles.
- door = 1 after 5 COOK cycles, held 10 cycles -> PAUSE, heat = 0, light = 1, remaining frozen at 2; door = 0 -> resumes; total COOK cycles still 12.
- start with remaining = 0 -> stays in CLOSED; load and start in the same cycle -> loads, does not start.
- cancel mid-COOK -> CLOSED, remaining = 0; door = 1 in the 2nd BELL cycle -> OPEN, bell = 0.
- rst = 1 mid-COOK -> next cycle CLOSED, all outputs 0, remaining = 0.
